// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_pkg
// Brief    : Shared types and encodings for the multi-cycle MIPS control FSM
// Revision : 1.0
// ============================================================================
package mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC   = 4'd2,
    ST_WB_ALU = 4'd3,
    ST_ADDR   = 4'd4,
    ST_MEM_RD = 4'd5,
    ST_MEM_WR = 4'd6,
    ST_WB_MEM = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9,
    ST_JUMPR  = 4'd10,
    ST_TRAP   = 4'd11
  } state_t;

  typedef enum logic [3:0] {
    CL_RTYPE   = 4'd0,
    CL_IALU    = 4'd1,
    CL_LOAD    = 4'd2,
    CL_STORE   = 4'd3,
    CL_BRANCH  = 4'd4,
    CL_JUMP    = 4'd5,
    CL_JAL     = 4'd6,
    CL_JR      = 4'd7,
    CL_ILLEGAL = 4'd8
  } iclass_t;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_NOR  = 5'd5;
  localparam logic [4:0] ALU_SLL  = 5'd6;
  localparam logic [4:0] ALU_SRL  = 5'd7;
  localparam logic [4:0] ALU_SRA  = 5'd8;
  localparam logic [4:0] ALU_SGN  = 5'd9;
  localparam logic [4:0] ALU_LEZ  = 5'd10;
  localparam logic [4:0] ALU_GTZ  = 5'd11;
  localparam logic [4:0] ALU_LUI  = 5'd12;
  localparam logic [4:0] ALU_SLTU = 5'd13;
  localparam logic [4:0] ALU_SLT  = 5'd14;
  localparam logic [4:0] ALU_SLLV = 5'd15;
  localparam logic [4:0] ALU_SRLV = 5'd16;
  localparam logic [4:0] ALU_SRAV = 5'd17;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_A     = 2'd1;
  localparam logic [1:0] SRCA_SHAMT = 2'd2;

  localparam logic [2:0] SRCB_B       = 3'd0;
  localparam logic [2:0] SRCB_FOUR    = 3'd1;
  localparam logic [2:0] SRCB_SIMM    = 3'd2;
  localparam logic [2:0] SRCB_SIMM_SH = 3'd3;
  localparam logic [2:0] SRCB_ZIMM    = 3'd4;
  localparam logic [2:0] SRCB_RT0     = 3'd5;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_A      = 2'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  typedef struct packed {
    iclass_t    cls;
    logic [4:0] alu_op;
    logic [1:0] src_a;
    logic [2:0] src_b;
    logic [1:0] reg_dst;
    logic       br_inv;
    logic       illegal;
  } dec_t;

endpackage
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
// Module   : mc_decode
// Brief    : Combinational opcode/funct/rt decode into class and ALU controls
// Revision : 1.0
// ============================================================================
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic [4:0] i_rt,
  output dec_t       o_dec
);

  always_comb begin
    o_dec.cls     = CL_ILLEGAL;
    o_dec.alu_op  = ALU_ADD;
    o_dec.src_a   = SRCA_A;
    o_dec.src_b   = SRCB_B;
    o_dec.reg_dst = REGDST_RT;
    o_dec.br_inv  = 1'b0;
    o_dec.illegal = 1'b0;

    case (i_opcode)
      OP_RTYPE: begin
        o_dec.cls     = CL_RTYPE;
        o_dec.reg_dst = REGDST_RD;
        case (i_funct)
          FN_ADD, FN_ADDU: o_dec.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: o_dec.alu_op = ALU_SUB;
          FN_AND:  o_dec.alu_op = ALU_AND;
          FN_OR:   o_dec.alu_op = ALU_OR;
          FN_XOR:  o_dec.alu_op = ALU_XOR;
          FN_NOR:  o_dec.alu_op = ALU_NOR;
          FN_SLT:  o_dec.alu_op = ALU_SLT;
          FN_SLTU: o_dec.alu_op = ALU_SLTU;
          FN_SLLV: o_dec.alu_op = ALU_SLLV;
          FN_SRLV: o_dec.alu_op = ALU_SRLV;
          FN_SRAV: o_dec.alu_op = ALU_SRAV;
          // Constant shifts take the shift amount from the instruction field
          FN_SLL: begin o_dec.alu_op = ALU_SLL; o_dec.src_a = SRCA_SHAMT; end
          FN_SRL: begin o_dec.alu_op = ALU_SRL; o_dec.src_a = SRCA_SHAMT; end
          FN_SRA: begin o_dec.alu_op = ALU_SRA; o_dec.src_a = SRCA_SHAMT; end
          FN_JR:   o_dec.cls = CL_JR;
          default: o_dec.cls = CL_ILLEGAL;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin o_dec.cls = CL_IALU; o_dec.alu_op = ALU_ADD;  o_dec.src_b = SRCB_SIMM; end
      OP_SLTI:           begin o_dec.cls = CL_IALU; o_dec.alu_op = ALU_SLT;  o_dec.src_b = SRCB_SIMM; end
      OP_SLTIU:          begin o_dec.cls = CL_IALU; o_dec.alu_op = ALU_SLTU; o_dec.src_b = SRCB_SIMM; end
      OP_LUI:            begin o_dec.cls = CL_IALU; o_dec.alu_op = ALU_LUI;  o_dec.src_b = SRCB_SIMM; end
      OP_ANDI:           begin o_dec.cls = CL_IALU; o_dec.alu_op = ALU_AND;  o_dec.src_b = SRCB_ZIMM; end
      OP_ORI:            begin o_dec.cls = CL_IALU; o_dec.alu_op = ALU_OR;   o_dec.src_b = SRCB_ZIMM; end
      OP_XORI:           begin o_dec.cls = CL_IALU; o_dec.alu_op = ALU_XOR;  o_dec.src_b = SRCB_ZIMM; end
      OP_LW:             o_dec.cls = CL_LOAD;
      OP_SW:             o_dec.cls = CL_STORE;
      OP_BEQ:            begin o_dec.cls = CL_BRANCH; o_dec.alu_op = ALU_SUB; end
      OP_BNE:            begin o_dec.cls = CL_BRANCH; o_dec.alu_op = ALU_SUB; o_dec.br_inv = 1'b1; end
      OP_BLEZ:           begin o_dec.cls = CL_BRANCH; o_dec.alu_op = ALU_LEZ; end
      OP_BGTZ:           begin o_dec.cls = CL_BRANCH; o_dec.alu_op = ALU_GTZ; end
      OP_REGIMM: begin
        // rt[0] picks bgez vs bltz; the ALU sees it through the rt0 operand
        if (i_rt == 5'd0 || i_rt == 5'd1) begin
          o_dec.cls    = CL_BRANCH;
          o_dec.alu_op = ALU_SGN;
          o_dec.src_b  = SRCB_RT0;
        end
      end
      OP_J:    o_dec.cls = CL_JUMP;
      OP_JAL:  o_dec.cls = CL_JAL;
      default: o_dec.cls = CL_ILLEGAL;
    endcase

    o_dec.illegal = (o_dec.cls == CL_ILLEGAL);
  end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Brief    : Multi-cycle MIPS control FSM driving a single time-shared ALU
// Revision : 1.0
// ============================================================================
module mc_ctrl
  import mc_pkg::*;
#(
  parameter logic [3:0] RESET_STATE     = 4'd0,
  parameter bit         TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic [4:0] rt_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic [4:0] alu_op_o,
  output logic [1:0] alu_src_a_o,
  output logic [2:0] alu_src_b_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       ir_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       iord_o,
  output logic       reg_write_o,
  output logic [1:0] reg_dst_o,
  output logic [1:0] mem_to_reg_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  state_t     r_state;
  state_t     w_state_nxt;
  state_t     w_bad_nxt;
  dec_t       w_dec;
  iclass_t    r_cls;
  logic [4:0] r_alu_op;
  logic [1:0] r_src_a;
  logic [2:0] r_src_b;
  logic [1:0] r_reg_dst;
  logic       r_br_inv;
  logic       r_illegal;
  logic       w_taken;

  mc_decode u_decode (
    .i_opcode (opcode_i),
    .i_funct  (funct_i),
    .i_rt     (rt_i),
    .o_dec    (w_dec)
  );

  generate
    if (TRAP_ON_ILLEGAL) begin : g_trap
      assign w_bad_nxt = ST_TRAP;
    end else begin : g_nop
      assign w_bad_nxt = ST_FETCH;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= state_t'(RESET_STATE);
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Instruction class and ALU controls are frozen at DECODE for the later states
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cls     <= CL_RTYPE;
      r_alu_op  <= ALU_ADD;
      r_src_a   <= SRCA_PC;
      r_src_b   <= SRCB_B;
      r_reg_dst <= REGDST_RT;
      r_br_inv  <= 1'b0;
      r_illegal <= 1'b0;
    end else if (r_state == ST_DECODE) begin
      r_cls     <= w_dec.cls;
      r_alu_op  <= w_dec.alu_op;
      r_src_a   <= w_dec.src_a;
      r_src_b   <= w_dec.src_b;
      r_reg_dst <= w_dec.reg_dst;
      r_br_inv  <= w_dec.br_inv;
      r_illegal <= r_illegal | w_dec.illegal;
    end
  end

  always_comb begin
    w_state_nxt = ST_FETCH;
    case (r_state)
      ST_FETCH:  w_state_nxt = mem_ready_i ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (w_dec.cls)
          CL_RTYPE, CL_IALU:  w_state_nxt = ST_EXEC;
          CL_LOAD, CL_STORE:  w_state_nxt = ST_ADDR;
          CL_BRANCH:          w_state_nxt = ST_BRANCH;
          CL_JUMP, CL_JAL:    w_state_nxt = ST_JUMP;
          CL_JR:              w_state_nxt = ST_JUMPR;
          default:            w_state_nxt = w_bad_nxt;
        endcase
      end
      ST_EXEC:   w_state_nxt = ST_WB_ALU;
      ST_ADDR:   w_state_nxt = (r_cls == CL_LOAD) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD: w_state_nxt = mem_ready_i ? ST_WB_MEM : ST_MEM_RD;
      ST_MEM_WR: w_state_nxt = mem_ready_i ? ST_FETCH : ST_MEM_WR;
      ST_TRAP:   w_state_nxt = ST_TRAP;
      default:   w_state_nxt = ST_FETCH;
    endcase
  end

  assign w_taken = zero_i ^ r_br_inv;

  always_comb begin
    alu_op_o     = ALU_ADD;
    alu_src_a_o  = SRCA_PC;
    alu_src_b_o  = SRCB_B;
    pc_write_o   = 1'b0;
    pc_src_o     = PCSRC_ALU;
    ir_write_o   = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    iord_o       = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = REGDST_RT;
    mem_to_reg_o = M2R_ALUOUT;
    // Gating on rst keeps every strobe low from the asserting edge onward
    if (!rst) begin
      case (r_state)
        ST_FETCH: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = SRCB_FOUR;
          ir_write_o  = mem_ready_i;
          pc_write_o  = mem_ready_i;
        end
        ST_DECODE: alu_src_b_o = SRCB_SIMM_SH;
        ST_EXEC: begin
          alu_op_o    = r_alu_op;
          alu_src_a_o = r_src_a;
          alu_src_b_o = r_src_b;
        end
        ST_WB_ALU: begin
          reg_write_o = 1'b1;
          reg_dst_o   = r_reg_dst;
        end
        ST_ADDR: begin
          alu_src_a_o = SRCA_A;
          alu_src_b_o = SRCB_SIMM;
        end
        ST_MEM_RD: begin
          mem_read_o = 1'b1;
          iord_o     = 1'b1;
        end
        ST_MEM_WR: begin
          mem_write_o = 1'b1;
          iord_o      = 1'b1;
        end
        ST_WB_MEM: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = M2R_MDR;
        end
        ST_BRANCH: begin
          alu_op_o    = r_alu_op;
          alu_src_a_o = SRCA_A;
          alu_src_b_o = r_src_b;
          pc_src_o    = PCSRC_ALUOUT;
          pc_write_o  = w_taken;
        end
        ST_JUMP: begin
          pc_write_o = 1'b1;
          pc_src_o   = PCSRC_JUMP;
          if (r_cls == CL_JAL) begin
            reg_write_o  = 1'b1;
            reg_dst_o    = REGDST_RA;
            mem_to_reg_o = M2R_PC;
          end
        end
        ST_JUMPR: begin
          pc_write_o = 1'b1;
          pc_src_o   = PCSRC_A;
        end
        default: ;
      endcase
    end
  end

  assign illegal_o = r_illegal;
  assign state_o   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl
// Brief    : Table-driven, scoreboard-checked bench for the mc_ctrl FSM
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mc_ctrl;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic [4:0] rt = 5'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic [4:0] alu_op;
  logic [1:0] src_a;
  logic [2:0] src_b;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       illegal;
  logic [3:0] state;

  mc_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .opcode_i     (opcode),
    .funct_i      (funct),
    .rt_i         (rt),
    .zero_i       (zero),
    .mem_ready_i  (mem_ready),
    .alu_op_o     (alu_op),
    .alu_src_a_o  (src_a),
    .alu_src_b_o  (src_b),
    .pc_write_o   (pc_write),
    .pc_src_o     (pc_src),
    .ir_write_o   (ir_write),
    .mem_read_o   (mem_read),
    .mem_write_o  (mem_write),
    .iord_o       (iord),
    .reg_write_o  (reg_write),
    .reg_dst_o    (reg_dst),
    .mem_to_reg_o (mem_to_reg),
    .illegal_o    (illegal),
    .state_o      (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [4:0] aop;
    logic [1:0] sa;
    logic [2:0] sb;
    logic       pcw;
    logic [1:0] pcs;
    logic       irw;
    logic       mrd;
    logic       mwr;
    logic       iord;
    logic       rw;
    logic [1:0] rdst;
    logic [1:0] m2r;
    logic       ill;
  } out_t;

  typedef struct {
    out_t  e;
    string tag;
  } sb_t;

  typedef enum int {K_ALU, K_LW, K_SW, K_BR, K_J, K_JAL, K_JR} kind_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    kind_t      kind;
    logic [4:0] aop;
    logic [1:0] sa;
    logic [2:0] sb;
    logic [1:0] rdst;
    logic       zero;
    logic       taken;
    int         fwait;
    int         mwait;
  } vec_t;

  sb_t  q[$];
  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic out_t e_st(input state_t s);
    out_t o = '0;
    o.st = s;
    return o;
  endfunction

  function automatic out_t e_fetch(input logic rdy);
    out_t o = e_st(ST_FETCH);
    o.mrd = 1'b1; o.sb = 3'd1; o.irw = rdy; o.pcw = rdy;
    return o;
  endfunction

  function automatic out_t e_decode();
    out_t o = e_st(ST_DECODE);
    o.sb = 3'd3;
    return o;
  endfunction

  function automatic out_t e_exec(input logic [4:0] aop, input logic [1:0] sa, input logic [2:0] sb);
    out_t o = e_st(ST_EXEC);
    o.aop = aop; o.sa = sa; o.sb = sb;
    return o;
  endfunction

  function automatic out_t e_wb_alu(input logic [1:0] rdst);
    out_t o = e_st(ST_WB_ALU);
    o.rw = 1'b1; o.rdst = rdst;
    return o;
  endfunction

  function automatic out_t e_addr();
    out_t o = e_st(ST_ADDR);
    o.sa = 2'd1; o.sb = 3'd2;
    return o;
  endfunction

  function automatic out_t e_mem(input logic wr);
    out_t o = e_st(wr ? ST_MEM_WR : ST_MEM_RD);
    o.mrd = ~wr; o.mwr = wr; o.iord = 1'b1;
    return o;
  endfunction

  function automatic out_t e_wb_mem();
    out_t o = e_st(ST_WB_MEM);
    o.rw = 1'b1; o.m2r = 2'd1;
    return o;
  endfunction

  function automatic out_t e_branch(input logic [4:0] aop, input logic [2:0] sb, input logic taken);
    out_t o = e_st(ST_BRANCH);
    o.aop = aop; o.sa = 2'd1; o.sb = sb; o.pcs = 2'd1; o.pcw = taken;
    return o;
  endfunction

  function automatic out_t e_jump(input logic link);
    out_t o = e_st(ST_JUMP);
    o.pcw = 1'b1; o.pcs = 2'd2;
    if (link) begin o.rw = 1'b1; o.rdst = 2'd2; o.m2r = 2'd2; end
    return o;
  endfunction

  function automatic out_t e_jumpr();
    out_t o = e_st(ST_JUMPR);
    o.pcw = 1'b1; o.pcs = 2'd3;
    return o;
  endfunction

  function automatic out_t e_trap();
    out_t o = e_st(ST_TRAP);
    o.ill = 1'b1;
    return o;
  endfunction

  // Drive one cycle's inputs just after the edge and queue what that cycle must show
  task automatic step(input logic r, input logic rdy, input logic z, input out_t e, input string tag);
    sb_t s;
    @(posedge clk);
    #1;
    rst = r; mem_ready = rdy; zero = z;
    s.e = e; s.tag = tag;
    q.push_back(s);
  endtask

  always @(negedge clk) begin
    sb_t  s;
    out_t got;
    if (q.size() > 0) begin
      s = q.pop_front();
      got = '{st: state, aop: alu_op, sa: src_a, sb: src_b, pcw: pc_write, pcs: pc_src,
              irw: ir_write, mrd: mem_read, mwr: mem_write, iord: iord, rw: reg_write,
              rdst: reg_dst, m2r: mem_to_reg, ill: illegal};
      n_cmp++;
      if (got !== s.e) begin
        n_bad++;
        $display("FAIL %s: got %b expected %b (state %0d vs %0d)", s.tag, got, s.e, got.st, s.e.st);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    opcode = v.op; funct = v.fn; rt = v.rt;
    for (int i = 0; i < v.fwait; i++) step(1'b0, 1'b0, 1'b0, e_fetch(1'b0), {v.name, " fetch-wait"});
    step(1'b0, 1'b1, 1'b0, e_fetch(1'b1), {v.name, " fetch"});
    step(1'b0, 1'b1, 1'b0, e_decode(), {v.name, " decode"});
    case (v.kind)
      K_ALU: begin
        step(1'b0, 1'b1, 1'b0, e_exec(v.aop, v.sa, v.sb), {v.name, " exec"});
        step(1'b0, 1'b1, 1'b0, e_wb_alu(v.rdst), {v.name, " wb_alu"});
      end
      K_LW, K_SW: begin
        step(1'b0, 1'b1, 1'b0, e_addr(), {v.name, " addr"});
        for (int i = 0; i < v.mwait; i++)
          step(1'b0, 1'b0, 1'b0, e_mem(v.kind == K_SW), {v.name, " mem-wait"});
        step(1'b0, 1'b1, 1'b0, e_mem(v.kind == K_SW), {v.name, " mem"});
        if (v.kind == K_LW) step(1'b0, 1'b1, 1'b0, e_wb_mem(), {v.name, " wb_mem"});
      end
      K_BR:    step(1'b0, 1'b1, v.zero, e_branch(v.aop, v.sb, v.taken), {v.name, " branch"});
      K_J:     step(1'b0, 1'b1, 1'b0, e_jump(1'b0), {v.name, " jump"});
      K_JAL:   step(1'b0, 1'b1, 1'b0, e_jump(1'b1), {v.name, " jump"});
      default: step(1'b0, 1'b1, 1'b0, e_jumpr(), {v.name, " jumpr"});
    endcase
  endtask

  initial begin
    //           name      op     fn     rt    kind   aop    sa    sb    rdst  z     tk    fw mw
    vecs.push_back('{"add",   6'h00, 6'h20, 5'd0, K_ALU, 5'd0,  2'd1, 3'd0, 2'd1, 1'b0, 1'b0, 0, 0});
    vecs.push_back('{"sub",   6'h00, 6'h22, 5'd0, K_ALU, 5'd1,  2'd1, 3'd0, 2'd1, 1'b0, 1'b0, 2, 0});
    vecs.push_back('{"sra",   6'h00, 6'h03, 5'd0, K_ALU, 5'd8,  2'd2, 3'd0, 2'd1, 1'b0, 1'b0, 0, 0});
    vecs.push_back('{"srlv",  6'h00, 6'h06, 5'd0, K_ALU, 5'd16, 2'd1, 3'd0, 2'd1, 1'b0, 1'b0, 0, 0});
    vecs.push_back('{"slt",   6'h00, 6'h2A, 5'd0, K_ALU, 5'd14, 2'd1, 3'd0, 2'd1, 1'b0, 1'b0, 0, 0});
    vecs.push_back('{"nor",   6'h00, 6'h27, 5'd0, K_ALU, 5'd5,  2'd1, 3'd0, 2'd1, 1'b0, 1'b0, 0, 0});
    vecs.push_back('{"addi",  6'h08, 6'h3F, 5'd0, K_ALU, 5'd0,  2'd1, 3'd2, 2'd0, 1'b0, 1'b0, 0, 0});
    vecs.push_back('{"ori",   6'h0D, 6'h00, 5'd0, K_ALU, 5'd3,  2'd1, 3'd4, 2'd0, 1'b0, 1'b0, 0, 0});
    vecs.push_back('{"sltiu", 6'h0B, 6'h00, 5'd0, K_ALU, 5'd13, 2'd1, 3'd2, 2'd0, 1'b0, 1'b0, 0, 0});
    vecs.push_back('{"lui",   6'h0F, 6'h00, 5'd0, K_ALU, 5'd12, 2'd1, 3'd2, 2'd0, 1'b0, 1'b0, 0, 0});
    vecs.push_back('{"lw",    6'h23, 6'h00, 5'd0, K_LW,  5'd0,  2'd0, 3'd0, 2'd0, 1'b0, 1'b0, 0, 2});
    vecs.push_back('{"sw",    6'h2B, 6'h00, 5'd0, K_SW,  5'd0,  2'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1, 1});
    vecs.push_back('{"beq-t", 6'h04, 6'h00, 5'd0, K_BR,  5'd1,  2'd1, 3'd0, 2'd0, 1'b1, 1'b1, 0, 0});
    vecs.push_back('{"beq-n", 6'h04, 6'h00, 5'd0, K_BR,  5'd1,  2'd1, 3'd0, 2'd0, 1'b0, 1'b0, 0, 0});
    vecs.push_back('{"bne-n", 6'h05, 6'h00, 5'd0, K_BR,  5'd1,  2'd1, 3'd0, 2'd0, 1'b1, 1'b0, 0, 0});
    vecs.push_back('{"bne-t", 6'h05, 6'h00, 5'd0, K_BR,  5'd1,  2'd1, 3'd0, 2'd0, 1'b0, 1'b1, 0, 0});
    vecs.push_back('{"bltz",  6'h01, 6'h00, 5'd0, K_BR,  5'd9,  2'd1, 3'd5, 2'd0, 1'b1, 1'b1, 0, 0});
    vecs.push_back('{"bgez",  6'h01, 6'h00, 5'd1, K_BR,  5'd9,  2'd1, 3'd5, 2'd0, 1'b0, 1'b0, 0, 0});
    vecs.push_back('{"j",     6'h02, 6'h00, 5'd0, K_J,   5'd0,  2'd0, 3'd0, 2'd0, 1'b0, 1'b0, 0, 0});
    vecs.push_back('{"jal",   6'h03, 6'h00, 5'd0, K_JAL, 5'd0,  2'd0, 3'd0, 2'd0, 1'b0, 1'b0, 0, 0});
    vecs.push_back('{"jr",    6'h00, 6'h08, 5'd0, K_JR,  5'd0,  2'd0, 3'd0, 2'd0, 1'b0, 1'b0, 0, 0});

    // Reset held with memory ready: FETCH strobes must still be suppressed
    step(1'b1, 1'b1, 1'b0, e_st(ST_FETCH), "reset-1");
    step(1'b1, 1'b1, 1'b0, e_st(ST_FETCH), "reset-2");
    step(1'b0, 1'b0, 1'b0, e_fetch(1'b0), "post-reset idle");

    foreach (vecs[i]) run_vec(vecs[i]);

    // Illegal opcode traps and stays trapped whatever memory does
    opcode = 6'h3F; funct = 6'h00; rt = 5'd0;
    step(1'b0, 1'b1, 1'b0, e_fetch(1'b1), "illegal fetch");
    step(1'b0, 1'b1, 1'b0, e_decode(), "illegal decode");
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e_trap(), "trap hold");
    step(1'b1, 1'b0, 1'b0, e_st(ST_FETCH), "trap reset");
    step(1'b0, 1'b0, 1'b0, e_fetch(1'b0), "trap release");

    // Reset arriving while a store is stalled in MEM_WR
    opcode = 6'h2B;
    step(1'b0, 1'b1, 1'b0, e_fetch(1'b1), "sw-rst fetch");
    step(1'b0, 1'b1, 1'b0, e_decode(), "sw-rst decode");
    step(1'b0, 1'b1, 1'b0, e_addr(), "sw-rst addr");
    step(1'b0, 1'b0, 1'b0, e_mem(1'b1), "sw-rst mem_wr-1");
    step(1'b0, 1'b0, 1'b0, e_mem(1'b1), "sw-rst mem_wr-2");
    step(1'b1, 1'b1, 1'b0, e_st(ST_FETCH), "rst in mem_wr");
    step(1'b0, 1'b0, 1'b0, e_fetch(1'b0), "after mem_wr rst");
    run_vec(vecs[0]);

    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard-drain: got %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of test, expected finish before 100000ns");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
